// File: rtl/sprite_view_writer_pkg.sv
// Shared constants for the sprite evaluation path: entry layout, view table
// geometry, the clear word and the evaluator FSM states.
package sprite_view_writer_pkg;

    localparam int BYTE           = 8;
    localparam int SPRITE_NUM_MAX = 8;
    localparam int TILE_H         = 8;

    // Bit positions inside one 32-bit sprite entry (OAM and view RAM alike).
    localparam int POSX_LSB   = 24;
    localparam int POSY_LSB   = 16;
    localparam int TILE_LSB   = 8;
    localparam int FLIP_A_BIT = 7;
    localparam int FLIP_B_BIT = 6;
    localparam int PAL_LO_LSB = 4;
    localparam int PAL_HI_BIT = 3;

    // posY=0xFF keeps a cleared slot off every visible line.
    localparam logic [31:0] SPRITE_VIEW_CLEAR_WORD = 32'h00FF_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_CLEAR,
        ST_DONE
    } viewState_t;

endpackage

// File: rtl/sprite_view_writer_hit_cmp.sv
// Combinational vertical hit test: does a sprite's tile band cover lineY?
// Kept standalone so a collision unit can reuse it.
module sprite_hit_cmp #(
    parameter int TILE_H = 8
) (
    input  logic [7:0] lineY,
    input  logic [7:0] posY,
    output logic       hit
);

    logic [8:0] diff;
    logic [7:0] tileH8;

    // The 9th bit catches posY > lineY, so bands never wrap past line 0xFF.
    assign diff   = {1'b0, lineY} - {1'b0, posY};
    assign tileH8 = 8'(TILE_H);
    assign hit    = ~diff[8] && (diff[7:0] < tileH8);

endmodule

// File: rtl/sprite_view_writer.sv
// Per-scanline sprite evaluator: scans OAM, copies covering sprites into the
// view table, clears the unused slots and reports count / overflow.
module sprite_view_writer
    import sprite_view_writer_pkg::*;
#(
    parameter int OAM_NUM  = 64,
    parameter int VIEW_NUM = sprite_view_writer_pkg::SPRITE_NUM_MAX,
    parameter int TILE_H   = sprite_view_writer_pkg::TILE_H,
    parameter int ENTRY_W  = 4 * sprite_view_writer_pkg::BYTE
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        start_i,
    input  logic [7:0]                  lineY_i,
    output logic [$clog2(OAM_NUM)-1:0]  oamAddr_o,
    input  logic [ENTRY_W-1:0]          oamData_i,
    output logic                        viewWe_o,
    output logic [$clog2(VIEW_NUM)-1:0] viewAddr_o,
    output logic [ENTRY_W-1:0]          viewData_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic [$clog2(VIEW_NUM):0]   spriteCount_o,
    output logic                        overflow_o
);

    localparam int AW = $clog2(OAM_NUM);
    localparam int VW = $clog2(VIEW_NUM);
    localparam int CW = VW + 1;

    viewState_t    state, stateNext;
    logic [AW-1:0] addrCnt;
    logic          addrActive;
    logic          rdValid;
    logic [AW-1:0] evalIdx;
    logic [7:0]    lineY;
    logic [CW-1:0] slotCnt, slotCntNext;
    logic [VW-1:0] clrIdx;

    logic               weR, doneR, overflowR;
    logic [VW-1:0]      viewAddrR;
    logic [ENTRY_W-1:0] viewDataR;
    logic [CW-1:0]      spriteCountR;

    logic               weNext, doneNext, ovfHit, slotInc;
    logic [VW-1:0]      addrNext;
    logic [ENTRY_W-1:0] dataNext;
    logic               hit, lastEval;

    sprite_hit_cmp #(.TILE_H(TILE_H)) u_hitCmp (
        .lineY (lineY),
        .posY  (oamData_i[POSY_LSB +: BYTE]),
        .hit   (hit)
    );

    assign lastEval    = rdValid && (evalIdx == AW'(OAM_NUM - 1));
    assign slotCntNext = slotCnt + CW'(slotInc);

    // NOTE: every signal gets a default before the case, otherwise the
    // unassigned branches would infer latches.
    always_comb begin
        stateNext = state;
        weNext    = 1'b0;
        addrNext  = '0;
        dataNext  = '0;
        doneNext  = 1'b0;
        ovfHit    = 1'b0;
        slotInc   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_i) stateNext = ST_SCAN;
            end
            ST_SCAN: begin
                if (rdValid && hit) begin
                    if (slotCnt == CW'(VIEW_NUM)) begin
                        ovfHit    = 1'b1;
                        doneNext  = 1'b1;
                        stateNext = ST_IDLE;
                    end else begin
                        weNext   = 1'b1;
                        addrNext = slotCnt[VW-1:0];
                        dataNext = oamData_i;
                        slotInc  = 1'b1;
                    end
                end
                if (lastEval && !ovfHit)
                    stateNext = (slotCntNext < CW'(VIEW_NUM)) ? ST_CLEAR : ST_DONE;
            end
            ST_CLEAR: begin
                weNext   = 1'b1;
                addrNext = clrIdx;
                dataNext = ENTRY_W'(SPRITE_VIEW_CLEAR_WORD);
                if (clrIdx == VW'(VIEW_NUM - 1)) stateNext = ST_DONE;
            end
            ST_DONE: begin
                doneNext  = 1'b1;
                stateNext = ST_IDLE;
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= ST_IDLE;
            addrCnt      <= '0;
            addrActive   <= 1'b0;
            rdValid      <= 1'b0;
            evalIdx      <= '0;
            lineY        <= '0;
            slotCnt      <= '0;
            clrIdx       <= '0;
            weR          <= 1'b0;
            viewAddrR    <= '0;
            viewDataR    <= '0;
            doneR        <= 1'b0;
            spriteCountR <= '0;
            overflowR    <= 1'b0;
        end else begin
            state     <= stateNext;
            weR       <= weNext;
            viewAddrR <= addrNext;
            viewDataR <= dataNext;
            doneR     <= doneNext;
            rdValid   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        lineY      <= lineY_i;
                        slotCnt    <= '0;
                        addrCnt    <= '0;
                        addrActive <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    // Read data trails its address by one cycle; rdValid/evalIdx track it.
                    if (stateNext != ST_SCAN) begin
                        addrActive <= 1'b0;
                    end else if (addrActive) begin
                        rdValid <= 1'b1;
                        evalIdx <= addrCnt;
                        if (addrCnt == AW'(OAM_NUM - 1)) addrActive <= 1'b0;
                        else                             addrCnt    <= addrCnt + AW'(1);
                    end
                    slotCnt <= slotCntNext;
                    if (stateNext == ST_CLEAR) clrIdx <= slotCntNext[VW-1:0];
                    if (ovfHit) begin
                        spriteCountR <= slotCnt;
                        overflowR    <= 1'b1;
                    end
                end
                ST_CLEAR: clrIdx <= clrIdx + VW'(1);
                ST_DONE: begin
                    spriteCountR <= slotCnt;
                    overflowR    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign oamAddr_o     = addrCnt;
    assign viewWe_o      = weR;
    assign viewAddr_o    = viewAddrR;
    assign viewData_o    = viewDataR;
    assign busy_o        = (state != ST_IDLE);
    assign done_o        = doneR;
    assign spriteCount_o = spriteCountR;
    assign overflow_o    = overflowR;

endmodule

// File: tb/tb_sprite_view_writer.sv
// Directed bench: OAM model with 1-cycle read latency, write scoreboard fed by
// a reference evaluator, cycle-exact checks of writes and completion.
module tb_sprite_view_writer;

    localparam int OAM_NUM  = 64;
    localparam int VIEW_NUM = 8;
    localparam int TILE_H   = 8;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        start_i = 1'b0;
    logic [7:0]  lineY_i = 8'h00;
    logic [5:0]  oamAddr_o;
    logic [31:0] oamData_i = 32'h0;
    logic        viewWe_o;
    logic [2:0]  viewAddr_o;
    logic [31:0] viewData_o;
    logic        busy_o;
    logic        done_o;
    logic [3:0]  spriteCount_o;
    logic        overflow_o;

    logic [31:0] oam [OAM_NUM];

    typedef struct {
        int          slot;
        logic [31:0] data;
        int          when;
    } wr_t;

    wr_t expQ[$];
    int  cyc = 0;
    int  startCyc = 0;
    int  total = 0;
    int  bad = 0;

    sprite_view_writer dut (
        .clk           (clk),
        .rstn          (rstn),
        .start_i       (start_i),
        .lineY_i       (lineY_i),
        .oamAddr_o     (oamAddr_o),
        .oamData_i     (oamData_i),
        .viewWe_o      (viewWe_o),
        .viewAddr_o    (viewAddr_o),
        .viewData_o    (viewData_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .spriteCount_o (spriteCount_o),
        .overflow_o    (overflow_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) oamData_i <= oam[oamAddr_o];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every view write must match the oldest expected one.
    always @(negedge clk) begin
        if (viewWe_o === 1'b1) begin
            check("write_expected", 64'(expQ.size() != 0), 64'd1);
            if (expQ.size() != 0) begin
                wr_t e;
                e = expQ.pop_front();
                check("write_slot", 64'(viewAddr_o), 64'(e.slot));
                check("write_data", 64'(viewData_o), 64'(e.data));
                check("write_cycle", 64'(cyc - startCyc), 64'(e.when));
            end
        end
    end

    function automatic logic [31:0] mkEntry(input int a, input logic [7:0] posY);
        logic [7:0] x, t, attr;
        x    = 8'(a * 3 + 1);
        t    = 8'(a + 8'h40);
        attr = 8'(a) ^ 8'hA5;
        return {x, posY, t, attr};
    endfunction

    task automatic fillOam(input logic [7:0] posY);
        for (int a = 0; a < OAM_NUM; a++) oam[a] = mkEntry(a, posY);
    endtask

    // Reference evaluator built directly from the hit rule and timing table.
    task automatic buildExpect(input logic [7:0] ly, output int expDone,
                               output int expCount, output int expOvf);
        int cnt = 0;
        int py;
        expOvf = 0;
        expDone = 0;
        expQ.delete();
        for (int a = 0; a < OAM_NUM; a++) begin
            py = int'(oam[a][23:16]);
            if (int'(ly) >= py && int'(ly) - py < TILE_H) begin
                if (cnt == VIEW_NUM) begin
                    expOvf  = 1;
                    expDone = 3 + a;
                    break;
                end
                expQ.push_back('{cnt, oam[a], 3 + a});
                cnt++;
            end
        end
        if (expOvf == 0) begin
            for (int j = cnt; j < VIEW_NUM; j++)
                expQ.push_back('{j, 32'h00FF_0000, OAM_NUM + 3 + (j - cnt)});
            expDone = OAM_NUM + 3 + (VIEW_NUM - cnt);
        end
        expCount = cnt;
    endtask

    task automatic runEval(input string tag, input logic [7:0] ly, input int extraAt);
        int  expDone, expCount, expOvf, rel;
        bit  seen = 0;
        buildExpect(ly, expDone, expCount, expOvf);
        @(negedge clk);
        start_i  = 1'b1;
        lineY_i  = ly;
        startCyc = cyc;
        @(negedge clk);
        start_i = 1'b0;
        lineY_i = 8'hAA;
        check({tag, "_busy_c1"}, 64'(busy_o), 64'd1);
        check({tag, "_addr_c1"}, 64'(oamAddr_o), 64'd0);
        rel = 1;
        for (int i = 0; i < 200; i++) begin
            rel = cyc - startCyc;
            if (done_o === 1'b1) begin
                seen = 1;
                break;
            end
            if (rel == extraAt) begin
                start_i = 1'b1;
                lineY_i = ly ^ 8'h5A;
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk);
        end
        start_i = 1'b0;
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        check({tag, "_done_cycle"}, 64'(rel), 64'(expDone));
        check({tag, "_count"}, 64'(spriteCount_o), 64'(expCount));
        check({tag, "_overflow"}, 64'(overflow_o), 64'(expOvf));
        check({tag, "_busy_done"}, 64'(busy_o), 64'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done_o), 64'd0);
        check({tag, "_count_hold"}, 64'(spriteCount_o), 64'(expCount));
        check({tag, "_pending"}, 64'(expQ.size()), 64'd0);
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_we"}, 64'(viewWe_o), 64'd0);
        check({tag, "_busy"}, 64'(busy_o), 64'd0);
        check({tag, "_done"}, 64'(done_o), 64'd0);
        check({tag, "_oamAddr"}, 64'(oamAddr_o), 64'd0);
        check({tag, "_viewAddr"}, 64'(viewAddr_o), 64'd0);
        check({tag, "_viewData"}, 64'(viewData_o), 64'd0);
        check({tag, "_count"}, 64'(spriteCount_o), 64'd0);
        check({tag, "_overflow"}, 64'(overflow_o), 64'd0);
    endtask

    initial begin
        int expDone, expCount, expOvf;
        fillOam(8'hFF);
        #1 rstn = 1'b0;
        #12;
        checkAllZero("reset");
        @(negedge clk);
        rstn = 1'b1;

        // Nothing visible: eight clears, done in cycle 75.
        runEval("empty", 8'h10, 0);

        // Two hits at entries 5 and 9.
        fillOam(8'hFF);
        oam[5] = mkEntry(5, 8'h0C);
        oam[9] = mkEntry(9, 8'h10);
        runEval("two", 8'h10, 0);

        // Same table with a second start while busy: must be ignored.
        runEval("busy_start", 8'h10, 20);

        // Band edges around lineY=0x20.
        fillOam(8'hFF);
        oam[0] = mkEntry(0, 8'h18);
        oam[1] = mkEntry(1, 8'h19);
        oam[2] = mkEntry(2, 8'h1C);
        oam[3] = mkEntry(3, 8'h20);
        oam[4] = mkEntry(4, 8'h21);
        runEval("band", 8'h20, 0);

        // No wrap at the top of the line range.
        fillOam(8'hFF);
        oam[3] = mkEntry(3, 8'hFC);
        oam[6] = mkEntry(6, 8'h00);
        runEval("nowrap", 8'h02, 0);

        fillOam(8'h00);
        oam[10] = mkEntry(10, 8'hF9);
        oam[11] = mkEntry(11, 8'hF7);
        runEval("bottom", 8'hFF, 0);

        // Entries 0..9 all hit: overflow on entry 8 in cycle 11.
        fillOam(8'hFF);
        for (int a = 0; a < 10; a++) oam[a] = mkEntry(a, 8'h40);
        runEval("overflow", 8'h43, 0);

        // Reset in cycle 30 of a scan with hits every 8 entries.
        fillOam(8'hFF);
        for (int a = 0; a < OAM_NUM; a += 8) oam[a] = mkEntry(a, 8'h50);
        buildExpect(8'h52, expDone, expCount, expOvf);
        @(negedge clk);
        start_i  = 1'b1;
        lineY_i  = 8'h52;
        startCyc = cyc;
        @(negedge clk);
        start_i = 1'b0;
        for (int i = 0; i < 100 && (cyc - startCyc) < 30; i++) @(negedge clk);
        check("rst_mid_cycle", 64'(cyc - startCyc), 64'd30);
        rstn = 1'b0;
        #1;
        checkAllZero("rst_mid");
        check("rst_mid_pending", 64'(expQ.size()), 64'd4);
        expQ.delete();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (100) @(negedge clk);
        check("rst_quiet_busy", 64'(busy_o), 64'd0);

        // Fresh start after reset: exactly eight hits, no clears.
        runEval("after_rst", 8'h52, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
